// File: rtl/ps2_host_phy_pkg.sv
// Shared definitions for the PS/2 host PHY: FSM states, frame bit indices, helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ps2_host_phy_pkg;

    // Protocol engine states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_TX_INH  = 3'd2,
        ST_TX_RTS  = 3'd3,
        ST_TX_BITS = 3'd4,
        ST_TX_ACK  = 3'd5,
        ST_TX_WAIT = 3'd6
    } state_t;

    // Bit positions after the start bit: 0..7 data, 8 parity, 9 stop
    localparam logic [3:0] BIT_PARITY = 4'd8;
    localparam logic [3:0] BIT_STOP   = 4'd9;

    // Cycle count for a duration in microseconds at a given clock rate
    function automatic int us_to_cyc(input int clk_rate, input int us);
        return (clk_rate / 1000000) * us;
    endfunction

    // Parity bit that makes the nine transmitted bits contain an odd number of ones
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/ps2_host_phy_line_filter.sv
// Conditions one asynchronous PS/2 pin: 2-flop synchroniser then a run-length glitch filter.
// Latency: 2 sync cycles + FILTER_LEN cycles from pin change to lvl change.
// Backpressure: none; free-running sampler.
module ps2_host_phy_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_in,
    output logic lvl
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          filt_q,  filt_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Accept a new level only after FILTER_LEN consecutive synced samples disagree with the current one
    always_comb begin
        sync1_d = pin_in;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Idle bus is high, so the synchroniser and filter come out of reset released
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lvl = filt_q;

endmodule

// File: rtl/ps2_host_phy.sv
// PS/2 host bit engine: device frames -> bytes, bytes -> host-to-device frames with ack check.
// Latency: produce 1 cycle after the filtered stop-bit fall; consume 1 cycle after IDLE accepts.
// Backpressure: a byte is taken only in IDLE with the clock line high; RX start has priority.
module ps2_host_phy
    import ps2_host_phy_pkg::*;
#(
    parameter int CLK_RATE   = 50000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 2000,
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_pd,
    input  logic       ps2_dat_in,
    output logic       ps2_dat_pd,
    input  logic [7:0] bs_data_in,
    input  logic       bs_data_in_valid,
    output logic       bs_data_in_consume,
    output logic [7:0] bs_data_out,
    output logic       bs_data_out_produce,
    output logic       rx_err,
    output logic       tx_err
);

    localparam int INH_CYC = us_to_cyc(CLK_RATE, INHIBIT_US);
    localparam int TO_CYC  = us_to_cyc(CLK_RATE, TIMEOUT_US);
    localparam int MAX_CYC = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    // Inhibit load is two short: the final inhibit cycle is spent in TX_RTS with data already low
    localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'((INH_CYC >= 2) ? (INH_CYC - 2) : 0);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TO_CYC - 1);

    logic clk_lvl;
    logic dat_lvl;
    logic clk_fall;

    ps2_host_phy_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk    (clk),
        .reset  (reset),
        .pin_in (ps2_clk_in),
        .lvl    (clk_lvl)
    );

    ps2_host_phy_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk    (clk),
        .reset  (reset),
        .pin_in (ps2_dat_in),
        .lvl    (dat_lvl)
    );

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [3:0]       bitcnt_q,  bitcnt_d;
    logic [7:0]       rx_sh_q,   rx_sh_d;
    logic             rx_par_q,  rx_par_d;
    logic [9:0]       tx_sh_q,   tx_sh_d;
    logic             clk_prev_q, clk_prev_d;
    logic             clk_pd_q,  clk_pd_d;
    logic             dat_pd_q,  dat_pd_d;
    logic [7:0]       out_q,     out_d;
    logic             produce_q, produce_d;
    logic             consume_q, consume_d;
    logic             rx_err_q,  rx_err_d;
    logic             tx_err_q,  tx_err_d;

    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_dec;

    assign clk_fall = clk_prev_q & ~clk_lvl;
    assign cnt_zero = (cnt_q == '0);
    assign cnt_dec  = cnt_q - CNT_W'(1);

    // Next-state, shifter, counter and registered-output logic of the frame engine
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        tx_sh_d    = tx_sh_q;
        clk_prev_d = clk_lvl;
        clk_pd_d   = clk_pd_q;
        dat_pd_d   = dat_pd_q;
        out_d      = out_q;
        produce_d  = 1'b0;
        consume_d  = 1'b0;
        rx_err_d   = 1'b0;
        tx_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_pd_d = 1'b0;
                dat_pd_d = 1'b0;
                // A device start bit beats a pending TX byte; the byte stays upstream
                if (clk_fall && !dat_lvl) begin
                    state_d  = ST_RX;
                    bitcnt_d = '0;
                    cnt_d    = TO_LOAD;
                end else if (bs_data_in_valid && clk_lvl) begin
                    tx_sh_d   = {1'b1, odd_parity(bs_data_in), bs_data_in};
                    consume_d = 1'b1;
                    clk_pd_d  = 1'b1;
                    cnt_d     = INH_LOAD;
                    state_d   = ST_TX_INH;
                end
            end

            ST_RX: begin
                if (clk_fall) begin
                    cnt_d    = TO_LOAD;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q < BIT_PARITY) begin
                        rx_sh_d = {dat_lvl, rx_sh_q[7:1]};
                    end else if (bitcnt_q == BIT_PARITY) begin
                        rx_par_d = dat_lvl;
                    end else begin
                        if ((^{rx_sh_q, rx_par_q}) && dat_lvl) begin
                            out_d     = rx_sh_q;
                            produce_d = 1'b1;
                        end else begin
                            rx_err_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end else if (cnt_zero) begin
                    rx_err_d = 1'b1;
                    clk_pd_d = 1'b0;
                    dat_pd_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            ST_TX_INH: begin
                if (cnt_zero) begin
                    dat_pd_d = 1'b1;
                    state_d  = ST_TX_RTS;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            ST_TX_RTS: begin
                // Data is low; releasing the clock hands the bus to the device
                clk_pd_d = 1'b0;
                bitcnt_d = '0;
                cnt_d    = TO_LOAD;
                state_d  = ST_TX_BITS;
            end

            ST_TX_BITS: begin
                if (clk_fall) begin
                    cnt_d    = TO_LOAD;
                    dat_pd_d = ~tx_sh_q[bitcnt_q];
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == BIT_STOP) begin
                        state_d = ST_TX_ACK;
                    end
                end else if (cnt_zero) begin
                    tx_err_d = 1'b1;
                    clk_pd_d = 1'b0;
                    dat_pd_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            ST_TX_ACK: begin
                if (clk_fall) begin
                    tx_err_d = dat_lvl;
                    cnt_d    = TO_LOAD;
                    state_d  = ST_TX_WAIT;
                end else if (cnt_zero) begin
                    tx_err_d = 1'b1;
                    clk_pd_d = 1'b0;
                    dat_pd_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            ST_TX_WAIT: begin
                if (clk_lvl && dat_lvl) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    tx_err_d = 1'b1;
                    clk_pd_d = 1'b0;
                    dat_pd_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            default: begin
                clk_pd_d = 1'b0;
                dat_pd_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Single state register; async reset releases both lines immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
            tx_sh_q    <= '0;
            clk_prev_q <= 1'b1;
            clk_pd_q   <= 1'b0;
            dat_pd_q   <= 1'b0;
            out_q      <= '0;
            produce_q  <= 1'b0;
            consume_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_par_q   <= rx_par_d;
            tx_sh_q    <= tx_sh_d;
            clk_prev_q <= clk_prev_d;
            clk_pd_q   <= clk_pd_d;
            dat_pd_q   <= dat_pd_d;
            out_q      <= out_d;
            produce_q  <= produce_d;
            consume_q  <= consume_d;
            rx_err_q   <= rx_err_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign ps2_clk_pd          = clk_pd_q;
    assign ps2_dat_pd          = dat_pd_q;
    assign bs_data_in_consume  = consume_q;
    assign bs_data_out         = out_q;
    assign bs_data_out_produce = produce_q;
    assign rx_err              = rx_err_q;
    assign tx_err              = tx_err_q;

endmodule
